// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: length-prefixed little-endian words into IMEM, holding the core in reset until done.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_boot_loader #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_cnt
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    state_e              state_q, state_d;
    state_e              fin_state;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [23:0]         asm_q, asm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                crn_q, crn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept_state;
    logic                accept;
    logic                arm;
    logic [15:0]         new_len;
    logic [15:0]         cnt_inc;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // Ready is a pure function of state, forced low while reset is held.
    always_comb begin
        accept_state = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
`ifdef BOOT_CHECKSUM_EN
        accept_state = accept_state || (state_q == S_CSUM);
`endif
        s_ready = accept_state && !rst;
        accept  = s_valid && s_ready;
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        arm     = 1'b0;
        new_len = {s_data, len_q[7:0]};
        cnt_inc = 16'(cnt_q + 16'd1);
        fin_state = S_DONE;
`ifdef BOOT_CHECKSUM_EN
        csum_d    = csum_q;
        fin_state = S_CSUM;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) arm = 1'b1;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = s_data;
                    if (new_len == 16'd0)        state_d = fin_state;
                    else if (new_len > DEPTH_W)  state_d = S_ERR;
                    else                         state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    case (idx_q)
                        2'd0:    asm_d[7:0]   = s_data;
                        2'd1:    asm_d[15:8]  = s_data;
                        2'd2:    asm_d[23:16] = s_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {s_data, asm_q};
                            addr_d  = cnt_q[ADDR_W-1:0];
                            cnt_d   = cnt_inc;
                            if (cnt_inc == len_q) state_d = fin_state;
                        end
                    endcase
                    idx_d = 2'(idx_q + 2'd1);
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (accept) state_d = (s_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (start) arm = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (arm) begin
            state_d = S_LEN_LO;
            cnt_d   = 16'd0;
            idx_d   = 2'd0;
            asm_d   = 24'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = 8'd0;
`endif
        end

        busy_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) || (state_d == S_DATA);
`ifdef BOOT_CHECKSUM_EN
        busy_d = busy_d || (state_d == S_CSUM);
`endif
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
        // Release the core one edge after DONE is entered, never alongside the last write.
        crn_d  = (state_q == S_DONE) && (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (AUTO_START != 0) state_q <= S_LEN_LO;
            else                 state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crn_q   <= crn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst_n = crn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a default instance and a DEPTH=4, AUTO_START=0 instance.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start2 = 1'b0;
    logic        s_valid = 1'b0, s_valid2 = 1'b0;
    logic [7:0]  s_data = 8'h00, s_data2 = 8'h00;

    logic        s_ready, imem_we, core_rst_n, busy, done, err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] word_cnt;

    logic        s_ready2, imem_we2, core_rst_n2, busy2, done2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [15:0] word_cnt2;

    imem_boot_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    imem_boot_loader #(.ADDR_W(2), .DEPTH(4), .AUTO_START(0)) u_small (
        .clk(clk), .rst(rst), .start(start2), .s_valid(s_valid2), .s_data(s_data2),
        .s_ready(s_ready2), .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .core_rst_n(core_rst_n2), .busy(busy2), .done(done2), .err(err2), .word_cnt(word_cnt2)
    );

    always #5 clk = ~clk;

`ifdef BOOT_CHECKSUM_EN
    localparam bit CSUM     = 1'b1;
    localparam int RISE_LAT = 2;
`else
    localparam bit CSUM     = 1'b0;
    localparam int RISE_LAT = 1;
`endif

    localparam logic [7:0] PROG_B [22] = '{
        8'h05, 8'h00, 8'h93, 8'h04, 8'hF0, 8'h0F, 8'h13, 8'h05, 8'hA0, 8'h0A, 8'hB3,
        8'h85, 8'hA4, 8'h00, 8'h13, 8'h08, 8'h50, 8'h00, 8'h93, 8'h85, 8'hB5, 8'hFF};
    localparam logic [31:0] PROG_W [5] = '{
        32'h0FF00493, 32'h0AA00513, 32'h00A485B3, 32'h00500813, 32'hFFB58593};

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_we_cyc = -1;
    int          rise_cyc = -1;
    logic        prev_crn = 1'b0;
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp2_addr[$];
    logic [31:0] exp2_data[$];
    logic [7:0]  stim[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is popped against the scoreboard queues.
    always @(negedge clk) begin
        cyc++;
        if (imem_we) begin
            chk("crn_low_during_we", 32'(core_rst_n), 32'd0);
            if (exp_addr.size() == 0) begin
                chk("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
                chk("wr_data", imem_wdata, exp_data.pop_front());
            end
            last_we_cyc = cyc;
        end
        if (core_rst_n && !prev_crn) rise_cyc = cyc;
        prev_crn = core_rst_n;
        if (imem_we2) begin
            if (exp2_addr.size() == 0) begin
                chk("unexpected_we2", 32'(imem_addr2), 32'hFFFF_FFFF);
            end else begin
                chk("wr2_addr", 32'(imem_addr2), 32'(exp2_addr.pop_front()));
                chk("wr2_data", imem_wdata2, exp2_data.pop_front());
            end
        end
    end

    task automatic drive(input bit which, input logic v, input logic [7:0] d);
        if (which) begin s_valid2 = v; s_data2 = d; end
        else       begin s_valid  = v; s_data  = d; end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input bit which, input logic [7:0] b, input bit bp);
        int   guard = 0;
        logic rdy;
        if (bp) begin
            while ($urandom_range(1, 0) == 1) begin
                drive(which, 1'b0, 8'($urandom));
                @(negedge clk);
            end
        end
        drive(which, 1'b1, b);
        rdy = which ? s_ready2 : s_ready;
        while (!rdy && guard < 50) begin
            @(negedge clk);
            guard++;
            rdy = which ? s_ready2 : s_ready;
        end
        if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        drive(which, 1'b0, 8'h00);
    endtask

    task automatic send_stim(input bit which, input bit bp, input bit add_csum);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < stim.size(); i++) begin
            if (i >= 2) x = x ^ stim[i];
            send_byte(which, stim[i], bp);
        end
        if (add_csum && CSUM) send_byte(which, x, bp);
    endtask

    task automatic wait_end(input bit which);
        int guard = 0;
        while (!(which ? (done2 || err2) : (done || err)) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start(input bit which);
        if (which) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic load_prog();
        stim.delete();
        foreach (PROG_B[i]) stim.push_back(PROG_B[i]);
        for (int i = 0; i < 5; i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(PROG_W[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_crn", 32'(core_rst_n), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("auto_start_ready", 32'(s_ready), 32'd1);
        chk("auto_start_busy", 32'(busy), 32'd1);
        chk("small_idle_ready", 32'(s_ready2), 32'd0);

        // Program load
        load_prog();
        last_we_cyc = -1;
        rise_cyc = -1;
        send_stim(1'b0, 1'b0, 1'b1);
        wait_end(1'b0);
        repeat (3) @(negedge clk);
        chk("prog_done", 32'(done), 32'd1);
        chk("prog_err", 32'(err), 32'd0);
        chk("prog_word_cnt", 32'(word_cnt), 32'd5);
        chk("prog_busy", 32'(busy), 32'd0);
        chk("prog_crn", 32'(core_rst_n), 32'd1);
        chk("prog_rise_lat", 32'(rise_cyc - last_we_cyc), 32'(RISE_LAT));
        chk("prog_writes_drained", 32'(exp_addr.size()), 32'd0);

        // Restart from DONE, then backpressured load
        pulse_start(1'b0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_crn", 32'(core_rst_n), 32'd0);
        chk("restart_word_cnt", 32'(word_cnt), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        load_prog();
        send_stim(1'b0, 1'b1, 1'b1);
        wait_end(1'b0);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_word_cnt", 32'(word_cnt), 32'd5);

        // Zero length
        pulse_start(1'b0);
        stim = '{8'h00, 8'h00};
        send_stim(1'b0, 1'b0, 1'b1);
        wait_end(1'b0);
        repeat (2) @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_word_cnt", 32'(word_cnt), 32'd0);
        chk("zero_crn", 32'(core_rst_n), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        pulse_start(1'b0);
        stim = '{8'h00, 8'h00, 8'h01};
        send_stim(1'b0, 1'b0, 1'b0);
        wait_end(1'b0);
        chk("zero_bad_csum_err", 32'(err), 32'd1);

        pulse_start(1'b0);
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        exp_addr.push_back(0);
        exp_data.push_back(32'h0000_0013);
        send_stim(1'b0, 1'b0, 1'b0);
        wait_end(1'b0);
        repeat (2) @(negedge clk);
        chk("csum_bad_err", 32'(err), 32'd1);
        chk("csum_bad_crn", 32'(core_rst_n), 32'd0);

        pulse_start(1'b0);
        chk("csum_recover_err_clr", 32'(err), 32'd0);
        stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        exp_addr.push_back(0);
        exp_data.push_back(32'h0000_0013);
        send_stim(1'b0, 1'b0, 1'b1);
        wait_end(1'b0);
        chk("csum_good_done", 32'(done), 32'd1);
`endif

        // Reset mid-load, with an ignored start while busy
        pulse_start(1'b0);
        stim = '{8'h02, 8'h00, 8'h93, 8'h04, 8'hF0, 8'h0F, 8'h13, 8'h05};
        exp_addr.push_back(0);
        exp_data.push_back(32'h0FF00493);
        send_stim(1'b0, 1'b0, 1'b0);
        pulse_start(1'b0);
        chk("start_busy_ignored_busy", 32'(busy), 32'd1);
        chk("start_busy_ignored_cnt", 32'(word_cnt), 32'd1);
        s_valid = 1'b1;
        s_data = 8'hA0;
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_crn", 32'(core_rst_n), 32'd0);
        chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
        chk("midrst_wdata", imem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        load_prog();
        send_stim(1'b0, 1'b0, 1'b1);
        wait_end(1'b0);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_word_cnt", 32'(word_cnt), 32'd5);

        // Small instance: oversize length, then exactly DEPTH words
        chk("small_idle_busy", 32'(busy2), 32'd0);
        pulse_start(1'b1);
        stim = '{8'h05, 8'h00};
        send_stim(1'b1, 1'b0, 1'b0);
        wait_end(1'b1);
        repeat (2) @(negedge clk);
        chk("over_err", 32'(err2), 32'd1);
        chk("over_done", 32'(done2), 32'd0);
        chk("over_crn", 32'(core_rst_n2), 32'd0);
        chk("over_busy", 32'(busy2), 32'd0);
        chk("over_word_cnt", 32'(word_cnt2), 32'd0);

        pulse_start(1'b1);
        stim = '{8'h04, 8'h00};
        for (int i = 0; i < 16; i++) stim.push_back(8'(i));
        exp2_addr = '{0, 1, 2, 3};
        exp2_data = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        send_stim(1'b1, 1'b0, 1'b1);
        wait_end(1'b1);
        chk("full_done", 32'(done2), 32'd1);
        chk("full_word_cnt", 32'(word_cnt2), 32'd4);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_addr.size()), 32'd0);
        chk("scoreboard2_empty", 32'(exp2_addr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Byte-stream program loader that sits directly upstream of Pipeline_top.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit instruction words.
- Writes those words into the fetch-stage instruction memory through a write port.
- Holds the core in reset (core_rst_n low) until the load completes, then releases it.
- Replaces hierarchical IMEM preloading for system-level and FPGA bring-up.

Parameters:
- ADDR_W, 10, IMEM word-address width.
- DEPTH, 1024, IMEM capacity in words. Must be ≤ 2^ADDR_W and ≤ 65535.
- AUTO_START, 1. When 1, leaves reset directly into LEN_LO. When 0, waits in IDLE for start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; arms a new load from IDLE, DONE or ERR.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  IMEM write strobe, one cycle per word.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_wdata  out  32  IMEM write data.
- core_rst_n  out  1  active-low reset to Pipeline_top.
- busy  out  1  load in progress.
- done  out  1  load completed successfully.
- err  out  1  load aborted (length or checksum error).
- word_cnt  out  16  words written in the current load.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE, or LEN_LO when AUTO_START=1.
  - All outputs 0: s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, busy=0, done=0, err=0, word_cnt=0.
  - Byte index and assembly register cleared.
- Handshake:
  - A byte is accepted on a rising edge with s_valid && s_ready.
  - s_ready = 1 only in LEN_LO, LEN_HI, DATA and CSUM; combinational from state.
  - s_data is ignored when not accepted.
- States:
  - IDLE: start → LEN_LO.
  - LEN_LO: accept byte → len[7:0]; go to LEN_HI.
  - LEN_HI: accept byte → len[15:8].
    - len == 0 → CSUM if checksum is enabled, else DONE.
    - len > DEPTH → ERR.
    - Otherwise → DATA.
  - DATA: bytes fill the word little-endian; byte index 0..3, the first byte lands in [7:0].
    - On acceptance of byte 3: register imem_we=1, imem_wdata = assembled word, imem_addr = word_cnt[ADDR_W-1:0].
    - word_cnt increments on that same edge.
    - If this was word len-1 → CSUM (enabled) or DONE.
  - DONE: done=1, busy=0. core_rst_n goes to 1 on the edge after DONE is entered, so it is never high in the same cycle as the final imem_we.
  - ERR: err=1, busy=0, core_rst_n held 0.
- imem_we is a one-cycle registered pulse, issued in the cycle after byte 3 is accepted. Maximum rate is one word per 4 accepted bytes.
- busy = 1 in LEN_LO, LEN_HI, DATA, CSUM.
- start in DONE or ERR:
  - → LEN_LO; done and err are cleared.
  - core_rst_n = 0 on that same edge.
  - word_cnt and byte index cleared.
- start while busy is ignored.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst asserted mid-load aborts immediately:
  - No further writes.
  - Partially written IMEM contents are left as-is.
  - core_rst_n = 0.
- Stalls: s_valid low for any number of cycles in any accepting state holds all state; no timeout.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - A CSUM state follows the last data word (or LEN_HI when len == 0).
  - One byte is accepted in CSUM and compared with the running XOR of all DATA bytes; the length bytes are excluded.
  - Match → DONE; mismatch → ERR.
  - The running XOR resets on start and on rst.
- Undefined:
  - No CSUM state and no running XOR; ERR is reachable only via len > DEPTH.

Test Plan:
- Program load: AUTO_START=1; stream 05 00 93 04 F0 0F 13 05 A0 0A B3 85 A4 00 13 08 50 00 93 85 B5 FF.
  - Expect 5 imem_we pulses: addr 0..4, data 0x0FF00493, 0x0AA00513, 0x00A485B3, 0x00500813, 0xFFB58593.
  - Expect done=1; core_rst_n rises exactly one cycle after the last imem_we; x11 later reads 0x1A4.
- Backpressure: same stream with s_valid toggling randomly at 50%.
  - Identical writes and ordering; no byte lost or duplicated.
- Oversize: DEPTH=4, length bytes 05 00.
  - ERR after LEN_HI; err=1, zero imem_we pulses, core_rst_n stays 0.
- Zero length: stream 00 00 → DONE with word_cnt=0 and no writes.
  - With BOOT_CHECKSUM_EN: 00 00 00 → DONE; 00 00 01 → ERR.
- Checksum: BOOT_CHECKSUM_EN, one word 13 00 00 00.
  - Checksum byte 0x13 → done=1.
  - Checksum byte 0x12 → err=1, core_rst_n=0. A following start plus a correct stream recovers to done=1.
- Reset mid-load: assert rst after byte 2 of word 1.
  - Outputs return to reset values immediately; no imem_we occurs afterwards.
  - A full reload then completes normally.
